// File: rtl/fifo_rd_unpacker_buf.sv
// fifo_rd_unpacker_buf: two-entry word buffer that keeps words in FIFO order.
//   clk, srst       clock and synchronous active-high reset
//   push, push_data store a word (the caller never pushes into a full buffer)
//   pop             retire the head word (the caller never pops an empty buffer)
//   head            oldest stored word
//   count           number of stored words, 0..2
module fifo_rd_unpacker_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wptr;
  logic         rptr;

  // Push and pop in the same cycle move both pointers and leave count
  // unchanged. Entries stay distinct because a push only happens when
  // credit allows it.
  always_ff @(posedge clk) begin
    if (srst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= push_data;
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign head = mem[rptr];

endmodule

// File: rtl/fifo_rd_unpacker.sv
// fifo_rd_unpacker: reads IN_WIDTH words from an upstream FIFO and emits each
// word as RATIO = IN_WIDTH/OUT_WIDTH lanes, least-significant lane first.
//   clk, srst    clock and synchronous active-high reset
//   fifo_ren     read enable to the upstream FIFO
//   fifo_rdata   read data, valid the cycle after fifo_ren
//   fifo_rempty  upstream empty flag
//   m_valid/m_ready/m_data/m_last  output lane stream; m_last marks a word's final lane
module fifo_rd_unpacker #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 srst,
  output logic                 fifo_ren,
  input  logic [IN_WIDTH-1:0]  fifo_rdata,
  input  logic                 fifo_rempty,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic                 m_last
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  generate
    if ((OUT_WIDTH > IN_WIDTH) || ((IN_WIDTH % OUT_WIDTH) != 0)) begin : g_bad_ratio
      $error("fifo_rd_unpacker: IN_WIDTH must be an integer multiple of OUT_WIDTH");
    end
  endgenerate

  logic                rd_pend;   // read issued last cycle; data is on fifo_rdata now
  logic [IDX_W-1:0]    lane_idx;
  logic [IN_WIDTH-1:0] head_word;
  logic [1:0]          count;
  logic [1:0]          credit;
  logic                lane_last;
  logic                xfer;
  logic                pop;

  fifo_rd_unpacker_buf #(.W(IN_WIDTH)) u_buf (
    .clk       (clk),
    .srst      (srst),
    .push      (rd_pend),
    .push_data (fifo_rdata),
    .pop       (pop),
    .head      (head_word),
    .count     (count)
  );

  // Outputs are gated with srst so they read zero during the reset cycle
  // itself, before the registered state has cleared.
  assign m_valid   = !srst && (count != 2'd0);
  assign lane_last = (lane_idx == IDX_W'(RATIO - 1));
  assign xfer      = m_valid && m_ready;
  assign pop       = xfer && lane_last;
  assign m_last    = m_valid && lane_last;
  assign m_data    = m_valid ? head_word[int'(lane_idx)*OUT_WIDTH +: OUT_WIDTH] : '0;

  // Credit counts stored words plus the read in flight. Crediting the pop
  // of this cycle lets a new read start as a word retires, so the buffer
  // never runs dry with m_ready held high.
  assign credit   = count + 2'(rd_pend);
  assign fifo_ren = !srst && !fifo_rempty && ((credit - 2'(pop)) < 2'd2);

  always_ff @(posedge clk) begin
    if (srst) begin
      rd_pend  <= 1'b0;
      lane_idx <= '0;
    end else begin
      rd_pend <= fifo_ren;
      if (xfer) lane_idx <= lane_last ? '0 : lane_idx + 1'b1;
    end
  end

endmodule

// File: doc/fifo_rd_unpacker.md
FIFO_RD_UNPACKER -- requirements
Module: fifo_rd_unpacker

Interface
REQ-001 Parameter IN_WIDTH, default 32: FIFO read word width in bits.
REQ-002 Parameter OUT_WIDTH, default 8: output stream lane width in bits.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 srst  input  1  reset, synchronous, active-high.
REQ-005 fifo_ren  output  1  read enable to upstream sclkfifolut.
REQ-006 fifo_rdata  input  IN_WIDTH  FIFO read data, valid the cycle after fifo_ren is sampled high.
REQ-007 fifo_rempty  input  1  FIFO empty flag.
REQ-008 m_valid  output  1  output lane valid.
REQ-009 m_ready  input  1  downstream accepts lane when high with m_valid.
REQ-010 m_data  output  OUT_WIDTH  output lane data.
REQ-011 m_last  output  1  high with the final lane of each FIFO word.

Function
REQ-012 RATIO = IN_WIDTH/OUT_WIDTH; IN_WIDTH not an integer multiple of OUT_WIDTH, or OUT_WIDTH > IN_WIDTH, SHALL stop elaboration with an error; RATIO=1 is legal (pure pass-through buffer).
REQ-013 Each FIFO word SHALL be emitted as RATIO lanes, least-significant lane first: lane k = word[(k+1)*OUT_WIDTH-1 : k*OUT_WIDTH].
REQ-014 A lane transfers on a cycle with m_valid and m_ready both high; lane index SHALL advance only on transfer, wrap to 0 after lane RATIO-1, and m_last SHALL equal (lane index == RATIO-1) while m_valid.
REQ-015 m_data/m_last SHALL hold stable while m_valid high and m_ready low; m_valid SHALL not drop without a transfer.
REQ-016 Internal word buffer SHALL be 2 entries deep (FIFO order); credit = stored words + in-flight reads, never exceeding 2.
REQ-017 fifo_ren = !fifo_rempty && (credit - pop < 2), pop = transfer of a last lane this cycle; combinational path m_ready -> fifo_ren is permitted.
REQ-018 fifo_ren SHALL never be high while fifo_rempty is high.
REQ-019 A read issued in cycle N SHALL be captured at the end of cycle N+1; the word's first lane SHALL present m_valid in cycle N+2 when the buffer holds no earlier word.
REQ-020 With m_ready held high and the FIFO non-empty, the block SHALL sustain one lane per cycle with no bubbles, including at word boundaries and for RATIO=1.
REQ-021 Simultaneous capture and pop in one cycle SHALL keep stored count unchanged and preserve order.

Reset
REQ-022 While srst high: fifo_ren=0, m_valid=0, m_data=0, m_last=0, lane index=0, buffer and credit cleared.
REQ-023 srst mid-operation SHALL discard stored words, partial word and in-flight read; FIFO data arriving the cycle after srst SHALL be ignored.
REQ-024 First fifo_ren possible in the first cycle after srst deasserts.

Structure
REQ-025 No shared package; RATIO and lane-index width ($clog2(RATIO), minimum 1) are localparams.
REQ-026 Single module; the 2-entry word buffer MAY be a sub-module named fifo_rd_unpacker_buf; no other hierarchy.

Verification (bench instantiates sclkfifolut LOG2_FIFO_DEPTH=3, FIFO_WIDTH=32 upstream, OUT_WIDTH=8)
REQ-027 Write 0x44332211, m_ready=1 -> m_data 0x11,0x22,0x33,0x44 on consecutive cycles, m_last only on 0x44, exactly one fifo_ren pulse.
REQ-028 Write words 1..8 (FIFO full), m_ready=1 -> 32 consecutive valid lanes, bytes 01,00,00,00,02,... in order, no bubble after the first lane.
REQ-029 Same stream with m_ready toggling 1,0 each cycle -> identical byte sequence, m_data stable during every stall, FIFO level never underflows.
REQ-030 No writes for 50 cycles -> fifo_ren and m_valid stay 0.
REQ-031 srst pulse after 2 lanes of word 0x44332211 (FIFO reset too) -> m_valid 0 next cycle, no further lanes until new write; next write 0xDDCCBBAA emits 0xAA first.
REQ-032 RATIO=1 variant (OUT_WIDTH=32), words 1..8 pre-filled -> m_valid 2 cycles after first fifo_ren, then 8 consecutive words, m_last high on every lane.
